// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared PSRAM receive-path types, ID defaults and command opcodes
package psram_pkg;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } rx_state_t;

  localparam logic [7:0] PSRAM_MFID_DEF = 8'h0D;
  localparam logic [7:0] PSRAM_KGD_DEF  = 8'h5D;

  localparam logic [7:0] PSRAM_OP_RST_EN  = 8'h66;
  localparam logic [7:0] PSRAM_OP_RST     = 8'h99;
  localparam logic [7:0] PSRAM_OP_READ_ID = 8'h9F;

endpackage

// File: rtl/psram_rx_deser_if.sv
// rtl/psram_rx_deser_if.sv - valid/ready byte stream from the PSRAM deserializer to its consumer
interface psram_rx_deser_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/psram_rx_fifo.sv
// rtl/psram_rx_fifo.sv - small synchronous FIFO with registered head and valid
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
module psram_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             is_empty, do_push, do_pop;

  assign is_empty = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !is_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign wr_next  = wr_ptr + (AW+1)'(do_push);
  assign rd_next  = rd_ptr + (AW+1)'(do_pop);

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      valid  <= (wr_next != rd_next);
      if (wr_next == rd_next)
        head <= '0;
      else if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0]))
        head <= push_data;
      else
        head <= mem[rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push && !clr)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/psram_rx_deser.sv
// rtl/psram_rx_deser.sv - PSRAM SO deserializer: MSB-first byte packing into a FIFO with sticky status
// Optional Read-ID byte check is compiled in with PSRAM_ID_CHECK_EN.
module psram_rx_deser
  import psram_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] ID_MFID = PSRAM_MFID_DEF,
  parameter logic [7:0] ID_KGD  = PSRAM_KGD_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             ce_n,
  input  logic             capture_en,
  input  logic             so_in,
  input  logic             clr,
  psram_rx_deser_if.master rx,
  output logic             overflow,
  output logic             frame_err,
  output logic             id_ok,
  output logic             id_fail
);

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] byte_idx;
  logic       sample, byte_done, fifo_drop, unused_fifo_full;
  logic [7:0] byte_val;

  assign sample    = (state == RX_ACTIVE) && !ce_n && capture_en;
  assign byte_done = sample && (bit_cnt == 3'd7);
  assign byte_val  = {sr, so_in};

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      byte_idx <= '0;
      sr       <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          bit_cnt  <= '0;
          byte_idx <= '0;
          if (!ce_n)
            state <= RX_ACTIVE;
        end
        RX_ACTIVE: begin
          if (ce_n) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            byte_idx <= '0;
          end else if (capture_en) begin
            sr      <= byte_val[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && byte_idx != 8'hFF)
              byte_idx <= byte_idx + 8'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // ce_n rising with a partial byte held is a framing error; the bits are simply discarded.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == RX_ACTIVE && ce_n && bit_cnt != 3'd0)
        frame_err <= 1'b1;
      if (fifo_drop)
        overflow <= 1'b1;
    end
  end

  psram_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .clr         (clr),
    .push        (byte_done),
    .push_data   (byte_val),
    .pop         (rx.out_valid && rx.out_ready),
    .head        (rx.out_data),
    .valid       (rx.out_valid),
    .full        (unused_fifo_full),
    .drop        (fifo_drop)
  );

`ifdef PSRAM_ID_CHECK_EN
  logic mfid_match;

  // Verdict is taken when the second byte of a frame completes, so each frame reports once.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      mfid_match <= 1'b0;
      id_ok      <= 1'b0;
      id_fail    <= 1'b0;
    end else begin
      if (byte_done && byte_idx == 8'd0)
        mfid_match <= (byte_val == ID_MFID);
      if (clr) begin
        id_ok   <= 1'b0;
        id_fail <= 1'b0;
      end else if (byte_done && byte_idx == 8'd1) begin
        if (mfid_match && byte_val == ID_KGD)
          id_ok <= 1'b1;
        else
          id_fail <= 1'b1;
      end
    end
  end
`else
  logic [23:0] unused_id;

  assign unused_id = {ID_MFID, ID_KGD, byte_idx};
  assign id_ok     = 1'b0;
  assign id_fail   = 1'b0;
`endif

endmodule
